psum_accum_pipe: RTL

//  Parametrised partial-sum accumulator between the MAC/PE computing core and the output/requant stage.

---
 rtl/psum_accum_pipe_pkg.sv | 36 +++
 rtl/psum_accum_pipe_lane.sv | 81 ++++++++
 rtl/psum_accum_pipe.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/psum_accum_pipe_pkg.sv
//------------------------------------------------------------------------------
// Module   : psum_pkg
// Purpose  : Shared types, default sizing constants and the sign/zero
//            extension helper for the partial-sum accumulator pipeline.
// Contents : state_t (IDLE/RUN), KMAX_DEF, CT_MAX_DEF, CNT_W, CT_W, ext_w()
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package psum_pkg;

  localparam int KMAX_DEF   = 7;
  localparam int CT_MAX_DEF = 64;
  localparam int CNT_W      = $clog2(KMAX_DEF + 1);
  localparam int CT_W       = $clog2(CT_MAX_DEF) + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Extend the low 'width' bits of val to 64 bits. When is_signed is set the
  // bit at position width-1 is replicated upward, otherwise zeros are used.
  function automatic logic [63:0] ext_w(input logic [63:0] val,
                                        input int          width,
                                        input logic        is_signed);
    logic [63:0] mask;
    logic        msb;
    mask = {64{1'b1}} << width;
    msb  = is_signed & (|(val & (64'd1 << (width - 1))));
    return msb ? (val | mask) : (val & ~mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/psum_accum_pipe_lane.sv
//------------------------------------------------------------------------------
// Module   : psum_lane
// Purpose  : One accumulating lane. Adds the extended input beat to the
//            running sum (or restarts on the first beat), saturates or wraps
//            on overflow, and captures the post-processed (optionally ReLU'd)
//            result into psum on the last beat of a window.
// Ports    : clk, rst           clock / synchronous active-high reset
//            beat               a beat is accepted this cycle
//            first, last        accepted beat opens / closes a window
//            sat, relu          saturate-on-overflow, clamp negatives to 0
//            din   [IN_W]       lane input
//            psum  [ACC_W]      finished-window result (held)
//            ovf                this cycle's addition overflows
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module psum_lane
  import psum_pkg::*;
#(
  parameter int IN_W   = 10,
  parameter int ACC_W  = 22,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat,
  input  logic             first,
  input  logic             last,
  input  logic             sat,
  input  logic             relu,
  input  logic [IN_W-1:0]  din,
  output logic [ACC_W-1:0] psum,
  output logic             ovf
);

  // One guard bit above the accumulator width exposes overflow directly.
  localparam int SUM_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] S_MAX = {ACC_W{1'b1}} >> 1;
  localparam logic [ACC_W-1:0] S_MIN = ~S_MAX;

  logic [ACC_W-1:0] acc;
  logic [SUM_W-1:0] din_x;
  logic [SUM_W-1:0] acc_x;
  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] clamp_val;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] post_val;

  always_comb begin
    din_x = SUM_W'(ext_w(64'(din), IN_W, SIGNED != 0));
    // A new window restarts from the input rather than adding to stale state.
    acc_x = first ? '0 : SUM_W'(ext_w(64'(acc), ACC_W, SIGNED != 0));
    sum   = acc_x + din_x;
    if (SIGNED != 0) begin
      // Signed overflow: guard bit disagrees with the result sign bit.
      ovf       = sum[SUM_W-1] ^ sum[SUM_W-2];
      clamp_val = sum[SUM_W-1] ? S_MIN : S_MAX;
    end else begin
      ovf       = sum[SUM_W-1];
      clamp_val = '1;
    end
    acc_next = (ovf && sat) ? clamp_val : sum[ACC_W-1:0];
    post_val = (relu && (SIGNED != 0) && acc_next[ACC_W-1]) ? '0 : acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      psum <= '0;
    end else if (beat) begin
      acc <= acc_next;
      if (last) begin
        psum <= post_val;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/psum_accum_pipe.sv
//------------------------------------------------------------------------------
// Module   : psum_accum_pipe
// Purpose  : Partial-sum accumulator between the MAC/PE core and requant.
//            Sums LANES independent lanes over K*K*CT beats per window
//            (kernel row fastest, then channel tile, then kernel column) and
//            presents each finished window with valid/ready backpressure.
// Ports    : clk, rst                     clock / sync active-high reset
//            cfg_load, cfg_clear          latch config (IDLE) / abort window
//            cfg_kernel, cfg_ctiles       K (1..KMAX), CT (1..CT_MAX)
//            cfg_sat, cfg_relu            saturate on overflow, ReLU output
//            in_valid, in_ready, i_result input beat handshake and data
//            o_valid, o_ready, o_psum     result handshake and data
//            o_busy                       in RUN
//            o_err                        sticky illegal-config / overflow
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module psum_accum_pipe
  import psum_pkg::*;
#(
  parameter int LANES  = 896,
  parameter int IN_W   = 10,
  parameter int ACC_W  = 22,
  parameter int KMAX   = KMAX_DEF,
  parameter int CT_MAX = CT_MAX_DEF,
  parameter int SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_load,
  input  logic                     cfg_clear,
  input  logic [2:0]               cfg_kernel,
  input  logic [$clog2(CT_MAX):0]  cfg_ctiles,
  input  logic                     cfg_sat,
  input  logic                     cfg_relu,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*IN_W-1:0]    i_result,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [LANES*ACC_W-1:0]   o_psum,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int ROW_W = $clog2(KMAX + 1);
  localparam int CTC_W = $clog2(CT_MAX) + 1;

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] col;
  logic [ROW_W-1:0] k_cfg;
  logic [CTC_W-1:0] ct;
  logic [CTC_W-1:0] ct_cfg;
  logic             sat_cfg;
  logic             relu_cfg;

  logic             cfg_ok;
  logic             first_beat;
  logic             last_beat;
  logic             accept;
  logic             any_ovf;
  logic [LANES-1:0] lane_ovf;

  always_comb begin
    cfg_ok     = (cfg_kernel != 3'd0) && (int'(cfg_kernel) <= KMAX) &&
                 (cfg_ctiles != '0)   && (int'(cfg_ctiles) <= CT_MAX);
    first_beat = (row == ROW_W'(1)) && (ct == '0) && (col == ROW_W'(1));
    last_beat  = (row == k_cfg) && (ct == ct_cfg - CTC_W'(1)) && (col == k_cfg);
    // Only the closing beat is held back, and only while the previous result
    // is still waiting; a clear takes priority, so no beat is accepted then.
    in_ready   = (state == ST_RUN) && !cfg_clear &&
                 !(last_beat && o_valid && !o_ready);
    accept     = in_valid && in_ready;
    any_ovf    = |lane_ovf;
    o_busy     = (state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      row      <= '0;
      col      <= '0;
      ct       <= '0;
      k_cfg    <= '0;
      ct_cfg   <= '0;
      sat_cfg  <= 1'b0;
      relu_cfg <= 1'b0;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      // Taking the result and closing a new window in one cycle keeps valid.
      if (o_valid && o_ready) o_valid <= 1'b0;
      if (accept && last_beat) o_valid <= 1'b1;
      if (accept && any_ovf)   o_err   <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (cfg_load && !cfg_clear) begin
            if (cfg_ok) begin
              k_cfg    <= ROW_W'(cfg_kernel);
              ct_cfg   <= cfg_ctiles;
              sat_cfg  <= cfg_sat;
              relu_cfg <= cfg_relu;
              row      <= ROW_W'(1);
              ct       <= '0;
              col      <= ROW_W'(1);
              o_err    <= 1'b0;
              state    <= ST_RUN;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (cfg_clear) begin
            row   <= '0;
            ct    <= '0;
            col   <= '0;
            state <= ST_IDLE;
          end else if (accept) begin
            if (row == k_cfg) begin
              row <= ROW_W'(1);
              if (ct == ct_cfg - CTC_W'(1)) begin
                ct  <= '0;
                col <= (col == k_cfg) ? ROW_W'(1) : col + ROW_W'(1);
              end else begin
                ct <= ct + CTC_W'(1);
              end
            end else begin
              row <= row + ROW_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lanes
    psum_lane #(
      .IN_W   (IN_W),
      .ACC_W  (ACC_W),
      .SIGNED (SIGNED)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .beat  (accept),
      .first (first_beat),
      .last  (last_beat),
      .sat   (sat_cfg),
      .relu  (relu_cfg),
      .din   (i_result[i*IN_W +: IN_W]),
      .psum  (o_psum[i*ACC_W +: ACC_W]),
      .ovf   (lane_ovf[i])
    );
  end

endmodule

`default_nettype wire
